// File: rtl/msg_overlay_pkg.sv
// Shared constants for the message overlay: geometry, message ids, modes and glyph bitmaps.
// Bitmap rows are stored MSB-first, so bit BMP_W-1 is the leftmost cell (column 0).
package msg_overlay_pkg;

  localparam int BMP_W      = 20;
  localparam int BMP_H      = 20;
  localparam int NUM_MSG    = 4;
  localparam int SCALE_LOG2 = 3;
  localparam int MSG_W      = $clog2(NUM_MSG);
  localparam int ROW_W      = $clog2(BMP_H);
  localparam int COL_W      = $clog2(BMP_W);
  localparam int W_PIX      = BMP_W << SCALE_LOG2;
  localparam int H_PIX      = BMP_H << SCALE_LOG2;

  localparam logic [MSG_W-1:0] MSG_START = MSG_W'(0);
  localparam logic [MSG_W-1:0] MSG_LOSE  = MSG_W'(1);
  localparam logic [MSG_W-1:0] MSG_BLANK = MSG_W'(2);
  localparam logic [MSG_W-1:0] MSG_WIN   = MSG_W'(3);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_SLIDE  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic [BMP_W-1:0] BITMAP [NUM_MSG][BMP_H] = '{
    '{20'hFFFFF, 20'h80001, 20'hBDEF5, 20'hA1245, 20'hA1245, 20'hBD245, 20'h85245,
      20'h85245, 20'hBD245, 20'h80001, 20'h80001, 20'hBDEF5, 20'hA1295, 20'hA1295,
      20'hBDEE5, 20'hA1285, 20'hA1285, 20'hBD285, 20'h80001, 20'hFFFFF},
    '{20'h00000, 20'h21E7F, 20'h21240, 20'h21240, 20'h21240, 20'h2127E, 20'h21242,
      20'h21242, 20'h3DE7F, 20'h00000, 20'h00000, 20'h7FFFE, 20'h40002, 20'h4FFF2,
      20'h40002, 20'h4FFF2, 20'h40002, 20'h7FFFE, 20'h00000, 20'h00000},
    '{default: '0},
    '{20'h00000, 20'h6DB6D, 20'h44924, 20'h44924, 20'h55B24, 20'h55924, 20'h7FB24,
      20'h2AB24, 20'h2AB24, 20'h00000, 20'h00000, 20'h0F0F0, 20'h1F8F8, 20'h3FCFC,
      20'h1F8F8, 20'h0F0F0, 20'h06060, 20'h00000, 20'hFFFFF, 20'h00000}
  };

endpackage

// File: rtl/msg_glyph_rom.sv
// Registered glyph lookup: one bitmap cell per clock.
// Out-of-range indices read as dark so garbage coordinates can never produce X.
module msg_glyph_rom
  import msg_overlay_pkg::*;
(
  input  logic             clk,
  input  logic [MSG_W-1:0] i_msg,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic             o_bit
);

  logic w_in_range;
  assign w_in_range = ({1'b0, i_msg} < (MSG_W+1)'(NUM_MSG)) &&
                      (i_row < ROW_W'(BMP_H)) && (i_col < COL_W'(BMP_W));

  always_ff @(posedge clk) begin
    if (w_in_range) o_bit <= BITMAP[i_msg][i_row][COL_W'(BMP_W-1) - i_col];
    else            o_bit <= 1'b0;
  end

endmodule

// File: rtl/msg_overlay.sv
// Bitmap message overlay: frame-synchronised message/mode switching, blink and slide-in,
// and a two-stage pixel pipeline producing the per-pixel overlay enable.
module msg_overlay
  import msg_overlay_pkg::*;
#(
  parameter int ORG_X        = 240,
  parameter int ORG_Y        = 160,
  parameter int BLINK_FRAMES = 30,
  parameter int SLIDE_STEP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       i_px_x,
  input  logic [9:0]       i_px_y,
  input  logic             i_px_valid,
  input  logic             i_frame_start,
  input  logic             i_msg_req,
  input  logic [MSG_W-1:0] i_msg_sel,
  input  logic [1:0]       i_mode,
  output logic             o_msg_busy,
  output logic             o_overlay_on,
  output logic [MSG_W-1:0] o_cur_msg
);

  localparam int STAGES  = 2;
  localparam int SLIDE_W = $clog2(H_PIX + 1);
  localparam int BLK_W   = $clog2(BLINK_FRAMES + 1);
  localparam logic signed [10:0] ORG_X_S = 11'(ORG_X);
  localparam logic signed [10:0] ORG_Y_S = 11'(ORG_Y);
  localparam logic signed [10:0] W_PIX_S = 11'(W_PIX);
  localparam logic signed [10:0] H_PIX_S = 11'(H_PIX);

  logic [MSG_W-1:0]   r_cur_msg, r_pend_sel;
  mode_e              r_mode, r_pend_mode;
  logic               r_busy, r_visible;
  logic [BLK_W-1:0]   r_blink_cnt;
  logic [SLIDE_W-1:0] r_slide_off;

  // A request arriving on the frame_start cycle itself takes priority over the pending one.
  logic               w_apply;
  logic [MSG_W-1:0]   w_app_sel, w_app_msg;
  mode_e              w_app_mode;

  assign w_apply    = i_frame_start & (i_msg_req | r_busy);
  assign w_app_sel  = i_msg_req ? i_msg_sel : r_pend_sel;
  assign w_app_mode = i_msg_req ? mode_e'(i_mode) : r_pend_mode;
  assign w_app_msg  = ({1'b0, w_app_sel} >= (MSG_W+1)'(NUM_MSG)) ? MSG_BLANK : w_app_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_pend_sel  <= '0;
      r_pend_mode <= MODE_STATIC;
      r_cur_msg   <= MSG_BLANK;
      r_mode      <= MODE_STATIC;
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
      r_slide_off <= '0;
    end else if (i_frame_start) begin
      r_busy <= 1'b0;
      if (w_apply) begin
        r_cur_msg   <= w_app_msg;
        r_mode      <= w_app_mode;
        r_blink_cnt <= '0;
        r_visible   <= 1'b1;
        r_slide_off <= (w_app_mode == MODE_SLIDE) ? SLIDE_W'(H_PIX) : '0;
      end else begin
        if (r_mode == MODE_BLINK) begin
          if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
            r_blink_cnt <= '0;
            r_visible   <= ~r_visible;
          end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
          end
        end
        if (r_mode == MODE_SLIDE)
          r_slide_off <= (r_slide_off > SLIDE_W'(SLIDE_STEP)) ?
                         r_slide_off - SLIDE_W'(SLIDE_STEP) : '0;
      end
    end else if (i_msg_req) begin
      r_pend_sel  <= i_msg_sel;
      r_pend_mode <= mode_e'(i_mode);
      r_busy      <= 1'b1;
    end
  end

  // S1: window test and cell coordinates; the slide offset shifts the bitmap down.
  logic signed [10:0] w_dx, w_dy, w_slide_s, w_dy_rel;
  logic               w_in_win;

  assign w_dx      = $signed({1'b0, i_px_x}) - ORG_X_S;
  assign w_dy      = $signed({1'b0, i_px_y}) - ORG_Y_S;
  assign w_slide_s = $signed(11'(r_slide_off));
  assign w_dy_rel  = w_dy - w_slide_s;
  assign w_in_win  = i_px_valid && (w_dx >= 11'sd0) && (w_dx < W_PIX_S) &&
                     (w_dy >= w_slide_s) && (w_dy < H_PIX_S);

  logic [STAGES:1]  r_vld_pipe;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_rom_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_vld_pipe[1] <= w_in_win;
      r_vld_pipe[2] <= r_vld_pipe[1] & r_visible;
      r_row         <= ROW_W'(w_dy_rel >>> SCALE_LOG2);
      r_col         <= COL_W'(w_dx >>> SCALE_LOG2);
    end
  end

  // S2: the ROM register and the gate register share the same edge.
  msg_glyph_rom u_rom (
    .clk   (clk),
    .i_msg (r_cur_msg),
    .i_row (r_row),
    .i_col (r_col),
    .o_bit (w_rom_bit)
  );

  assign o_overlay_on = r_vld_pipe[STAGES] & w_rom_bit;
  assign o_msg_busy   = r_busy;
  assign o_cur_msg    = r_cur_msg;

endmodule
